// File: rtl/fru_config_loader.sv
// fru_config_loader
// Byte-serial configuration controller for the filter-reduce stage. It decodes
// packets addressed to PERSONAL_CONFIG_ID on the shared configId/configData
// bus. It updates the per-chain firmware registers (filter op, FUVRF address,
// reduce axis) and writes full FUVRF operand rows through RAM port B.
// Configuration is only accepted while tracing is low.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   tracing                datapath active; blocks configuration, aborts packets
//   config_valid           byte present on the bus this cycle
//   configId, configData   target block id, packet byte
//   firmware_filter_op     per-chain filter op        [MAX_CHAINS][8]
//   firmware_filter_addr   per-chain FUVRF row address [MAX_CHAINS][8]
//   firmware_reduce_axis   per-chain reduce axis      [MAX_CHAINS][8]
//   mem_address_b          FUVRF write address
//   mem_in_b               FUVRF write data (one full row)
//   mem_write_enable_b     FUVRF write strobe, one cycle per committed row
//   busy                   packet in progress
//   error                  sticky error flag (cleared by op 2 header)
module fru_config_loader #(
    parameter int unsigned M                 = 8,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned MAX_CHAINS        = 4,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
    parameter int unsigned FUVRF_SIZE        = 4,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_OP   = '0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_ADDR = '0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_REDUCE_AXIS = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tracing,
    input  logic                               config_valid,
    input  logic [7:0]                         configId,
    input  logic [7:0]                         configData,
    output logic [MAX_CHAINS-1:0][7:0]         firmware_filter_op,
    output logic [MAX_CHAINS-1:0][7:0]         firmware_filter_addr,
    output logic [MAX_CHAINS-1:0][7:0]         firmware_reduce_axis,
    output logic [$clog2(FUVRF_SIZE)-1:0]      mem_address_b,
    output logic [M*DATA_WIDTH-1:0]            mem_in_b,
    output logic                               mem_write_enable_b,
    output logic                               busy,
    output logic                               error
);

    localparam int unsigned ROW_W     = M * DATA_WIDTH;
    localparam int unsigned ROW_BYTES = ROW_W / 8;
    localparam int unsigned AW        = $clog2(FUVRF_SIZE);
    // Counter must also hold the 3-byte chain payload length
    localparam int unsigned CW        = ($clog2(ROW_BYTES + 1) < 2) ? 2 : $clog2(ROW_BYTES + 1);
    localparam int unsigned CIW       = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHAIN   = 2'd1,
        ST_ROW     = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_len;
    logic [CW-1:0]     w_len_next;
    logic [5:0]        r_idx;
    logic [7:0]        r_stage_op;
    logic [7:0]        r_stage_addr;
    logic [ROW_W-1:0]  r_row;

    logic              w_accept;
    logic [1:0]        w_op;
    logic [5:0]        w_idx;
    logic              w_chain_ok;
    logic              w_row_ok;
    logic              w_last;
    logic              w_err_set;
    logic              w_err_clr;
    logic              w_chain_done;
    logic              w_row_done;

    assign w_accept   = config_valid && (configId == PERSONAL_CONFIG_ID) && !tracing;
    assign w_op       = configData[7:6];
    assign w_idx      = configData[5:0];
    assign w_chain_ok = 32'(w_idx) < MAX_CHAINS;
    assign w_row_ok   = 32'(w_idx) < FUVRF_SIZE;
    assign w_last     = (r_cnt == (r_len - CW'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; abort wins because tracing blocks acceptance
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        w_chain_done = 1'b0;
        w_row_done   = 1'b0;
        if (tracing && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
            w_err_set    = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    case (w_op)
                        2'd0: begin
                            w_len_next = CW'(3);
                            if (w_chain_ok) begin
                                w_state_next = ST_CHAIN;
                            end else begin
                                w_state_next = ST_DISCARD;
                                w_err_set    = 1'b1;
                            end
                        end
                        2'd1: begin
                            w_len_next = CW'(ROW_BYTES);
                            if (w_row_ok) begin
                                w_state_next = ST_ROW;
                            end else begin
                                w_state_next = ST_DISCARD;
                                w_err_set    = 1'b1;
                            end
                        end
                        2'd2:    w_err_clr = 1'b1;
                        default: w_err_set = 1'b1;
                    endcase
                end
                ST_CHAIN: begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                        w_chain_done = 1'b1;
                    end
                end
                ST_ROW: begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                        w_row_done   = 1'b1;
                    end
                end
                default: begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Payload staging, firmware/RAM commit and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt                <= '0;
            r_len                <= '0;
            r_idx                <= '0;
            r_stage_op           <= '0;
            r_stage_addr         <= '0;
            r_row                <= '0;
            firmware_filter_op   <= INITIAL_FIRMWARE_FILTER_OP;
            firmware_filter_addr <= INITIAL_FIRMWARE_FILTER_ADDR;
            firmware_reduce_axis <= INITIAL_FIRMWARE_REDUCE_AXIS;
            mem_address_b        <= '0;
            mem_in_b             <= '0;
            mem_write_enable_b   <= 1'b0;
            busy                 <= 1'b0;
            error                <= 1'b0;
        end else begin
            r_len <= w_len_next;
            if (w_accept && (r_state == ST_IDLE)) begin
                r_cnt <= '0;
                r_idx <= w_idx;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_accept && (r_state == ST_CHAIN)) begin
                if (r_cnt == CW'(0)) r_stage_op   <= configData;
                if (r_cnt == CW'(1)) r_stage_addr <= configData;
            end

            // Bytes enter at the top so byte 0 ends up in the low lane
            if (w_accept && (r_state == ST_ROW)) begin
                r_row <= {configData, r_row[ROW_W-1:8]};
            end

            if (w_chain_done) begin
                firmware_filter_op[CIW'(r_idx)]   <= r_stage_op;
                firmware_filter_addr[CIW'(r_idx)] <= r_stage_addr;
                firmware_reduce_axis[CIW'(r_idx)] <= configData;
            end

            mem_write_enable_b <= w_row_done;
            if (w_row_done) begin
                mem_address_b <= AW'(r_idx);
                mem_in_b      <= {configData, r_row[ROW_W-1:8]};
            end

            if (w_err_set) begin
                error <= 1'b1;
            end else if (w_err_clr) begin
                error <= 1'b0;
            end

            busy <= (w_state_next != ST_IDLE);
        end
    end

endmodule
